// File: rtl/fifo_flagged.sv
// Show-ahead synchronous FIFO for any DEPTH, with occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_flagged #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] write_data,
    input  logic             flush,
    input  logic             clear_err,
    output logic [WIDTH-1:0] read_data,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int             PW    = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]  LAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0]  FULLC = CW'(DEPTH);
    localparam logic [CW-1:0]  AF_L  = CW'(AF_LEVEL);
    localparam logic [CW-1:0]  AE_L  = CW'(AE_LEVEL);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_ovf_evt;
    logic             w_unf_evt;
    logic [PW-1:0]    w_wr_next;
    logic [PW-1:0]    w_rd_next;

    // Handshake: a push is taken when not full, or when full and a pop is
    // taken in the same cycle; a pop is taken whenever the FIFO is non-empty.
    // Refused requests only set the sticky error flags; nothing is stalled.
    assign w_push_ok = push & (~full | pop);
    assign w_pop_ok  = pop & ~empty;
    assign w_ovf_evt = push & ~pop & full & ~flush;
    assign w_unf_evt = pop & empty & ~flush;

    assign w_wr_next = (r_wr_ptr == LAST) ? '0 : r_wr_ptr + PW'(1);
    assign w_rd_next = (r_rd_ptr == LAST) ? '0 : r_rd_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= w_wr_next;
            if (w_pop_ok)  r_rd_ptr <= w_rd_next;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Error flags: a new event in the same cycle as clear_err wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  & ~clear_err) | w_ovf_evt;
            r_underflow <= (r_underflow & ~clear_err) | w_unf_evt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && w_push_ok) r_mem[r_wr_ptr] <= write_data;
    end

    assign read_data    = r_mem[r_rd_ptr];
    assign count        = r_count;
    assign empty        = (r_count == '0);
    assign full         = (r_count == FULLC);
    assign almost_empty = (r_count <= AE_L);
    assign almost_full  = (r_count >= AF_L);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_flagged.sv
// Bench for fifo_flagged: a DEPTH=16 instance checked against a queue model
// and a DEPTH=5 instance checked with a vector table and wrap rounds.
module tb_fifo_flagged;

    localparam int D16 = 16;
    localparam int AF16 = D16 - 2;
    localparam int AE16 = 2;
    localparam int D5 = 5;
    localparam int AF5 = D5 - 2;
    localparam int AE5 = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       push16 = 0, pop16 = 0, flush16 = 0, clr16 = 0;
    logic [7:0] wd16 = '0, rd16;
    logic       empty16, full16, ae16, af16, ovf16, unf16;
    logic [4:0] count16;

    logic       push5 = 0, pop5 = 0, flush5 = 0, clr5 = 0;
    logic [7:0] wd5 = '0, rd5;
    logic       empty5, full5, ae5, af5, ovf5, unf5;
    logic [2:0] count5;

    int n_checks = 0;
    int n_errors = 0;

    // reference model for the DEPTH=16 instance
    logic [7:0] exp_q[$];
    bit m_ovf = 0, m_unf = 0;

    typedef struct {
        bit         push, pop, flush, clr;
        logic [7:0] data;
        int         exp_count;
        bit         exp_ovf, exp_unf;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t tbl[17];

    // clock / reset
    always #5 clk = ~clk;

    fifo_flagged #(.WIDTH(8), .DEPTH(D16)) u_d16 (
        .clk(clk), .rst(rst), .push(push16), .pop(pop16), .write_data(wd16),
        .flush(flush16), .clear_err(clr16), .read_data(rd16), .empty(empty16),
        .full(full16), .almost_empty(ae16), .almost_full(af16), .count(count16),
        .overflow(ovf16), .underflow(unf16)
    );

    fifo_flagged #(.WIDTH(8), .DEPTH(D5)) u_d5 (
        .clk(clk), .rst(rst), .push(push5), .pop(pop5), .write_data(wd5),
        .flush(flush5), .clear_err(clr5), .read_data(rd5), .empty(empty5),
        .full(full5), .almost_empty(ae5), .almost_full(af5), .count(count5),
        .overflow(ovf5), .underflow(unf5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(bit p, bit q, bit f, bit c, logic [7:0] d,
                                int cnt, bit ov, bit un, logic [7:0] rd);
        vec_t v;
        v.push = p; v.pop = q; v.flush = f; v.clr = c; v.data = d;
        v.exp_count = cnt; v.exp_ovf = ov; v.exp_unf = un; v.exp_rd = rd;
        return v;
    endfunction

    // queue model: update from the inputs seen at an edge
    task automatic model16(input bit p, input bit q, input logic [7:0] d,
                           input bit f, input bit c, input bit r);
        int sz;
        bit was_full, was_empty;
        sz = exp_q.size();
        was_full = (sz == D16);
        was_empty = (sz == 0);
        if (r) begin
            exp_q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            m_ovf = (m_ovf && !c) || (!f && p && !q && was_full);
            m_unf = (m_unf && !c) || (!f && q && was_empty);
            if (f) begin
                exp_q.delete();
            end else begin
                if (q && !was_empty) void'(exp_q.pop_front());
                if (p && (!was_full || q)) exp_q.push_back(d);
            end
        end
    endtask

    task automatic check16();
        int sz;
        sz = exp_q.size();
        chk("count16", 32'(count16), 32'(sz));
        chk("empty16", 32'(empty16), 32'(sz == 0));
        chk("full16", 32'(full16), 32'(sz == D16));
        chk("almost_empty16", 32'(ae16), 32'(sz <= AE16));
        chk("almost_full16", 32'(af16), 32'(sz >= AF16));
        chk("overflow16", 32'(ovf16), 32'(m_ovf));
        chk("underflow16", 32'(unf16), 32'(m_unf));
        if (sz > 0) chk("read_data16", 32'(rd16), 32'(exp_q[0]));
    endtask

    // driver tasks
    task automatic step16(input bit p, input bit q, input logic [7:0] d,
                          input bit f, input bit c, input bit r);
        push16 = p; pop16 = q; wd16 = d; flush16 = f; clr16 = c; rst = r;
        @(posedge clk);
        model16(p, q, d, f, c, r);
        #1;
        check16();
    endtask

    task automatic step5(input bit p, input bit q, input logic [7:0] d,
                         input bit f, input bit c);
        push5 = p; pop5 = q; wd5 = d; flush5 = f; clr5 = c;
        @(posedge clk);
        #1;
        push5 = 0; pop5 = 0; flush5 = 0; clr5 = 0;
    endtask

    initial begin
        logic [7:0] exp5_q[$];
        logic [7:0] v;

        tbl[0]  = mk(1, 0, 0, 0, 8'hA1, 1, 0, 0, 8'hA1);
        tbl[1]  = mk(1, 0, 0, 0, 8'hA2, 2, 0, 0, 8'hA1);
        tbl[2]  = mk(1, 0, 0, 0, 8'hA3, 3, 0, 0, 8'hA1);
        tbl[3]  = mk(1, 0, 0, 0, 8'hA4, 4, 0, 0, 8'hA1);
        tbl[4]  = mk(1, 0, 0, 0, 8'hA5, 5, 0, 0, 8'hA1);
        tbl[5]  = mk(1, 0, 0, 0, 8'hA6, 5, 1, 0, 8'hA1);
        tbl[6]  = mk(1, 1, 0, 0, 8'hA7, 5, 1, 0, 8'hA2);
        tbl[7]  = mk(0, 0, 0, 1, 8'h00, 5, 0, 0, 8'hA2);
        tbl[8]  = mk(0, 1, 0, 0, 8'h00, 4, 0, 0, 8'hA3);
        tbl[9]  = mk(0, 1, 0, 0, 8'h00, 3, 0, 0, 8'hA4);
        tbl[10] = mk(0, 1, 0, 0, 8'h00, 2, 0, 0, 8'hA5);
        tbl[11] = mk(0, 1, 0, 0, 8'h00, 1, 0, 0, 8'hA7);
        tbl[12] = mk(0, 1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        tbl[13] = mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 8'h00);
        tbl[14] = mk(1, 1, 0, 1, 8'hB1, 1, 0, 1, 8'hB1);
        tbl[15] = mk(0, 0, 0, 1, 8'h00, 1, 0, 0, 8'hB1);
        tbl[16] = mk(1, 1, 1, 0, 8'hC3, 0, 0, 0, 8'h00);

        // reset both instances
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check16();
        chk("reset_count5", 32'(count5), 0);
        chk("reset_empty5", 32'(empty5), 1);
        chk("reset_af5", 32'(af5), 0);

        // DEPTH=5 vector table
        for (int i = 0; i < 17; i++) begin
            step5(tbl[i].push, tbl[i].pop, tbl[i].data, tbl[i].flush, tbl[i].clr);
            chk($sformatf("tbl%0d_count", i), 32'(count5), 32'(tbl[i].exp_count));
            chk($sformatf("tbl%0d_empty", i), 32'(empty5), 32'(tbl[i].exp_count == 0));
            chk($sformatf("tbl%0d_full", i), 32'(full5), 32'(tbl[i].exp_count == D5));
            chk($sformatf("tbl%0d_ae", i), 32'(ae5), 32'(tbl[i].exp_count <= AE5));
            chk($sformatf("tbl%0d_af", i), 32'(af5), 32'(tbl[i].exp_count >= AF5));
            chk($sformatf("tbl%0d_ovf", i), 32'(ovf5), 32'(tbl[i].exp_ovf));
            chk($sformatf("tbl%0d_unf", i), 32'(unf5), 32'(tbl[i].exp_unf));
            if (tbl[i].exp_count > 0)
                chk($sformatf("tbl%0d_rd", i), 32'(rd5), 32'(tbl[i].exp_rd));
        end

        // DEPTH=5 wrap rounds: push 4 / pop 4, three times
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                v = 8'($urandom_range(255));
                exp5_q.push_back(v);
                step5(1, 0, v, 0, 0);
            end
            chk("wrap_count_full", 32'(count5), 4);
            for (int k = 0; k < 4; k++) begin
                chk("wrap_rd", 32'(rd5), 32'(exp5_q.pop_front()));
                step5(0, 1, 8'h00, 0, 0);
            end
            chk("wrap_count_zero", 32'(count5), 0);
            chk("wrap_empty", 32'(empty5), 1);
        end

        // fill 16 and drain in order
        for (int i = 0; i < 16; i++) step16(1, 0, 8'(i * 8'h11), 0, 0, 0);
        chk("fill_full", 32'(full16), 1);
        for (int i = 0; i < 16; i++) step16(0, 1, 8'h00, 0, 0, 0);
        chk("drain_empty", 32'(empty16), 1);

        // full with simultaneous push+pop
        for (int i = 0; i < 16; i++) step16(1, 0, 8'(8'h20 + i), 0, 0, 0);
        for (int i = 0; i < 20; i++) step16(1, 1, 8'(8'h40 + i), 0, 0, 0);
        chk("stream_overflow", 32'(ovf16), 0);

        // overflow, underflow, clear_err
        step16(1, 0, 8'hAA, 0, 0, 0);
        chk("drop_overflow", 32'(ovf16), 1);
        for (int i = 0; i < 16; i++) begin
            step16(0, 1, 8'h00, 0, 0, 0);
            if (!empty16) chk("no_AA_seen", 32'(rd16 == 8'hAA), 0);
        end
        step16(0, 1, 8'h00, 0, 0, 0);
        chk("pop_empty_underflow", 32'(unf16), 1);
        step16(0, 0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 16; i++) step16(1, 0, 8'(8'h60 + i), 0, 0, 0);
        step16(1, 0, 8'hAB, 0, 1, 0);
        chk("clear_vs_set_overflow", 32'(ovf16), 1);
        step16(0, 0, 8'h00, 0, 1, 0);

        // flush
        step16(0, 0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 7; i++) step16(1, 0, 8'(8'h70 + i), 0, 0, 0);
        step16(1, 1, 8'hEE, 1, 0, 0);
        chk("flush_count", 32'(count16), 0);
        step16(1, 0, 8'h5C, 0, 0, 0);
        chk("after_flush_rd", 32'(rd16), 32'h5C);

        // randomized run with reset mid-way
        for (int i = 0; i < 1000; i++) begin
            step16($urandom_range(99) < 60, $urandom_range(99) < 50,
                   8'($urandom_range(255)), $urandom_range(99) < 2,
                   $urandom_range(99) < 3, i == 500);
        end

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
